// File: rtl/regwrite_trace_monitor.sv
// regwrite_trace_monitor
//   Taps a MIPS register-file write-back port and records every write to a
//   watched register as a timestamped entry {cycle, pc, reg, data}. Entries
//   land in a show-ahead FIFO drained through a valid/ready port. Drops on a
//   full FIFO are counted in a sticky flag and a saturating counter.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   en, clear, halt arm capture / flush everything / core halted
//   watch_mask      bit i set -> register i is traced ($zero never is)
//   wb_valid, wb_reg, wb_data, pc   write-back tap
//   rd_valid, rd_ready              head-of-FIFO handshake
//   rd_cycle, rd_pc, rd_reg, rd_data head entry (zero while empty)
//   count, full, overflow, ovf_cnt  occupancy and drop accounting
//   state                           0=IDLE 1=RUN 2=HALTED
module regwrite_trace_monitor #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int CYC_W  = 32,
    parameter int DEPTH  = 16,
    parameter int OVF_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clear,
    input  logic                       halt,
    input  logic [31:0]                watch_mask,
    input  logic                       wb_valid,
    input  logic [4:0]                 wb_reg,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic [PC_W-1:0]            pc,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [CYC_W-1:0]           rd_cycle,
    output logic [PC_W-1:0]            rd_pc,
    output logic [4:0]                 rd_reg,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow,
    output logic [OVF_W-1:0]           ovf_cnt,
    output logic [1:0]                 state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]       st;
    logic [CYC_W-1:0] cycle;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr, rd_ptr, used;

    logic [CYC_W-1:0]  mem_cycle [DEPTH];
    logic [PC_W-1:0]   mem_pc    [DEPTH];
    logic [4:0]        mem_reg   [DEPTH];
    logic [DATA_W-1:0] mem_data  [DEPTH];

    logic capture, pop, push, drop, flush;

    assign flush   = !rst_n || clear;
    assign used    = wr_ptr - rd_ptr;
    assign count   = CW'(used);
    assign full    = (used == FULL_CNT);
    assign rd_valid = (used != '0);
    assign state   = st;

    assign capture = (st == ST_RUN) && wb_valid && (wb_reg != 5'd0) && watch_mask[wb_reg];
    assign pop     = rd_valid && rd_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_ff @(posedge clk) begin
        if (flush) begin
            st       <= ST_IDLE;
            cycle    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            ovf_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
            end
            // Counter value before this increment is the capture timestamp.
            if (st == ST_RUN) cycle <= cycle + 1'b1;
            case (st)
                ST_IDLE:   if (en) st <= ST_RUN;
                // halt wins over en dropping in the same cycle
                ST_RUN:    if (halt) st <= ST_HALTED;
                           else if (!en) st <= ST_IDLE;
                ST_HALTED: st <= ST_HALTED;
                default:   st <= ST_IDLE;
            endcase
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (!flush && push) begin
            mem_cycle[wr_ptr[AW-1:0]] <= cycle;
            mem_pc[wr_ptr[AW-1:0]]    <= pc;
            mem_reg[wr_ptr[AW-1:0]]   <= wb_reg;
            mem_data[wr_ptr[AW-1:0]]  <= wb_data;
        end
    end

    always_comb begin
        rd_cycle = '0;
        rd_pc    = '0;
        rd_reg   = '0;
        rd_data  = '0;
        if (rd_valid) begin
            rd_cycle = mem_cycle[rd_ptr[AW-1:0]];
            rd_pc    = mem_pc[rd_ptr[AW-1:0]];
            rd_reg   = mem_reg[rd_ptr[AW-1:0]];
            rd_data  = mem_data[rd_ptr[AW-1:0]];
        end
    end

endmodule

// File: doc/regwrite_trace_monitor.md
Name: regwrite_trace_monitor

Overview:
- Synthesizable trace capture block for the MIPS cores (single-cycle and successors).
- Taps the register-file write-back port and records each watched register write as a timestamped entry: cycle, PC, register index, data.
- Entries go into a parametrised show-ahead FIFO that a host or bench drains through a valid/ready port.
- Replaces per-cycle console dumps of fixed registers with a hardware trace that has a selectable register set, halt/flush control and overflow accounting.

Parameters:
- DATA_W, 32, width of write-back data and of rd_data
- PC_W, 32, width of pc and rd_pc
- CYC_W, 32, width of cycle timestamp
- DEPTH, 16, FIFO entries; power of two, >= 2
- OVF_W, 8, width of saturating overflow counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- en  in  1  arm capture; IDLE->RUN
- clear  in  1  synchronous flush of FIFO, counters and state to IDLE
- halt  in  1  core halted; RUN->HALTED
- watch_mask  in  32  bit i=1 means register i is traced
- wb_valid  in  1  register-file write enable this cycle
- wb_reg  in  5  destination register index
- wb_data  in  DATA_W  write data
- pc  in  PC_W  PC of the writing instruction
- rd_valid  out  1  head entry available
- rd_ready  in  1  consumer accepts head
- rd_cycle  out  CYC_W  head timestamp
- rd_pc  out  PC_W  head PC
- rd_reg  out  5  head register index
- rd_data  out  DATA_W  head data
- count  out  $clog2(DEPTH+1)  entries held
- full  out  1  count==DEPTH
- overflow  out  1  sticky; at least one capture dropped
- ovf_cnt  out  OVF_W  dropped captures, saturating
- state  out  2  0=IDLE, 1=RUN, 2=HALTED

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, cycle=0, FIFO empty, count=0, rd_valid=0, full=0, overflow=0, ovf_cnt=0. rd_* payload=0 while empty.
- clear=1 has the same effect as reset. Ignored while rst_n=0.
- State transitions:
  - IDLE->RUN when en=1.
  - RUN->HALTED when halt=1.
  - HALTED stays until clear or reset; en is ignored in HALTED.
  - RUN->IDLE when en=0; FIFO contents are retained.
- Cycle counter:
  - Increments by 1 every edge in RUN and wraps at 2^CYC_W.
  - Frozen in IDLE and HALTED.
  - Timestamp of a capture is the counter value before that edge's increment. The first RUN cycle is stamped 0.
- Capture condition: state==RUN, wb_valid=1, wb_reg!=0, watch_mask[wb_reg]=1. $zero writes are never traced.
- The write in the cycle halt rises is still captured (halt and capture share the same edge).
- No capture occurs in IDLE or HALTED.
- FIFO: show-ahead.
  - rd_valid = (count!=0); rd_* reflect the head combinationally.
  - Pop when rd_valid && rd_ready.
  - Push latency 1 cycle: a capture at edge N is visible on rd_* after edge N if the FIFO was empty.
- Simultaneous push and pop: both happen and count is unchanged. This holds when full, so push is accepted.
- Push while full without pop: entry dropped, overflow set (sticky), ovf_cnt += 1, saturating at 2^OVF_W-1.
- Pop on empty is ignored. Pointers wrap modulo DEPTH and use an extra wrap bit to distinguish full from empty.
- Draining is allowed in all states, including during HALTED and IDLE.
- Reset or clear mid-operation discards all entries immediately; rd_valid=0 on the next cycle.

Test Plan:
- Reset/arm: rst_n=0 for 2 edges, then en=1, watch_mask=0x00FF0000. Write $s0 (16) = 0x0000000A at RUN cycle 3 -> rd_valid=1 next cycle with rd_cycle=3, rd_reg=16, rd_data=0x0000000A and the matching rd_pc.
- Mask/zero filter: with mask=0xFFFFFFFF, writes to $0, $t0 (8)=0x5 and $t1 (9)=0x6 -> exactly 2 entries, reg 8 then reg 9, count=2. With mask bit 9 cleared, only reg 8 is recorded.
- Overflow: DEPTH=4, rd_ready=0, 6 consecutive watched writes -> full=1, count=4, overflow=1, ovf_cnt=2. Draining then yields the first 4 writes in order.
- Full push+pop: FIFO full, rd_ready=1 and a watched write in the same cycle -> count stays 4, ovf_cnt unchanged, the new entry appears last.
- Halt: write $s1=0x11 with halt=1 in the same cycle -> entry captured, state=HALTED. Further writes are ignored, the cycle counter stays frozen, and the FIFO drains normally.
- Clear mid-run: 3 entries held, clear=1 -> next cycle count=0, rd_valid=0, state=IDLE, overflow=0. The next en restarts timestamps at 0.
